// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with prescaled count tick, load/clear and programmable terminal value.
// All outputs registered: data/tick/wrap/load_err update one clk after the causing condition.
module bcd_updown_counter #(
  parameter int                   DIGITS = 6,
  parameter int                   DIV    = 500_000,
  parameter logic [4*DIGITS-1:0]  LIMIT  = {DIGITS{4'h9}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   data,
  output logic                  tick,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int              W    = 4 * DIGITS;
  localparam int              PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(DIV - 1);

  logic [W-1:0]  data_q, data_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          load_err_q, load_err_d;
  logic          step;
  logic          load_ok;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic carry;
    bcd_inc = v;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic borrow;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] v);
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
  endfunction

  // For valid BCD, numeric order equals unsigned order of the packed vector.
  assign load_ok = digits_ok(load_data) && (load_data <= LIMIT);
  assign step    = en && (presc_q == PMAX);

  always_comb begin
    data_d     = data_q;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      data_d  = '0;
      presc_d = '0;
    end else if (load) begin
      if (load_ok) begin
        data_d  = load_data;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      presc_d = step ? '0 : presc_q + 1'b1;
      if (step) begin
        tick_d = 1'b1;
        if (up_dn) begin
          if (data_q == LIMIT) begin
            data_d = '0;
            wrap_d = 1'b1;
          end else begin
            data_d = bcd_inc(data_q);
          end
        end else begin
          if (data_q == '0) begin
            data_d = LIMIT;
            wrap_d = 1'b1;
          end else begin
            data_d = bcd_dec(data_q);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign data     = data_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Three counter configurations share stimulus; an integer-arithmetic model feeds a scoreboard queue.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
  logic [23:0] load_data = '0;
  logic [23:0] dout [3];
  logic        tick_o [3];
  logic        wrap_o [3];
  logic        lerr_o [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int val;
    int presc;
    bit t;
    bit w;
    bit e;
  } mst_t;

  mst_t        m [3];
  int          divs [3] = '{4, 1, 1};
  int          lims [3] = '{999999, 999999, 235959};
  logic [26:0] sbq [$];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(6), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_data(load_data), .data(dout[0]), .tick(tick_o[0]), .wrap(wrap_o[0]), .load_err(lerr_o[0]));

  bcd_updown_counter #(.DIGITS(6), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_data(load_data), .data(dout[1]), .tick(tick_o[1]), .wrap(wrap_o[1]), .load_err(lerr_o[1]));

  bcd_updown_counter #(.DIGITS(6), .DIV(1), .LIMIT(24'h235959)) u_hms (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_data(load_data), .data(dout[2]), .tick(tick_o[2]), .wrap(wrap_o[2]), .load_err(lerr_o[2]));

  function automatic logic [23:0] int2bcd(input int v);
    int r;
    r = v;
    int2bcd = '0;
    for (int i = 0; i < 6; i++) begin
      int2bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  function automatic int bcd2int(input logic [23:0] b);
    bcd2int = 0;
    for (int i = 5; i >= 0; i--) bcd2int = bcd2int * 10 + int'(b[4*i +: 4]);
  endfunction

  function automatic mst_t mstep(input mst_t s, input int div, input int lim,
                                 input bit e, input bit ud, input bit c, input bit l,
                                 input logic [23:0] ld);
    mst_t n;
    bit   ok;
    n = s;
    n.t = 0; n.w = 0; n.e = 0;
    ok = 1;
    for (int i = 0; i < 6; i++) if (ld[4*i +: 4] > 4'd9) ok = 0;
    if (ok && bcd2int(ld) > lim) ok = 0;
    if (c) begin
      n.val = 0; n.presc = 0;
    end else if (l) begin
      if (ok) begin n.val = bcd2int(ld); n.presc = 0; end
      else n.e = 1;
    end else if (e) begin
      if (s.presc == div - 1) begin
        n.presc = 0;
        n.t = 1;
        if (ud) begin
          if (s.val == lim) begin n.val = 0; n.w = 1; end
          else n.val = s.val + 1;
        end else begin
          if (s.val == 0) begin n.val = lim; n.w = 1; end
          else n.val = s.val - 1;
        end
      end else begin
        n.presc = s.presc + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] obs_of(input int k);
    return {dout[k], tick_o[k], wrap_o[k], lerr_o[k]};
  endfunction

  // One clock: drive inputs, push model predictions, compare after the edge.
  task automatic cyc(input bit e, input bit ud, input bit c, input bit l, input logic [23:0] ld);
    logic [26:0] exp;
    en = e; up_dn = ud; clear = c; load = l; load_data = ld;
    for (int k = 0; k < 3; k++) begin
      m[k] = mstep(m[k], divs[k], lims[k], e, ud, c, l, ld);
      sbq.push_back({int2bcd(m[k].val), m[k].t, m[k].w, m[k].e});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp = sbq.pop_front();
      chk($sformatf("sb_dut%0d", k), obs_of(k), exp);
    end
  endtask

  task automatic run(input int n, input bit ud);
    for (int i = 0; i < n; i++) cyc(1'b1, ud, 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) m[k] = '{0, 0, 0, 0, 0};
    #12;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_dut%0d", k), obs_of(k), 27'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Count up from reset: 9->10 boundary, DIV=4 reaches 12 after 48 cycles.
    run(3, 1'b1);
    chk("no_tick_before_div", {26'h0, tick_o[0]}, 27'h0);
    run(1, 1'b1);
    chk("first_tick_cycle4", obs_of(0), {24'h000001, 3'b100});
    run(44, 1'b1);
    chk("div4_after_48", {3'b0, dout[0]}, {3'b0, 24'h000012});

    // 99 -> 100 carry ripple.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h000095);
    run(24, 1'b1);
    chk("ripple_to_101", {3'b0, dout[0]}, {3'b0, 24'h000101});

    // Up-wrap at all-9s; 999998 exceeds the hh:mm:ss limit.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h999998);
    chk("load_over_limit_err", {26'h0, lerr_o[2]}, 27'h1);
    run(1, 1'b1);
    chk("up_to_999999", obs_of(1), {24'h999999, 3'b100});
    run(1, 1'b1);
    chk("up_wrap_zero", obs_of(1), {24'h000000, 3'b110});
    run(4, 1'b1);

    // Down: borrow ripple and wrap to LIMIT.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h001000);
    run(1, 1'b0);
    chk("down_borrow", {3'b0, dout[1]}, {3'b0, 24'h000999});
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    run(1, 1'b0);
    chk("down_wrap_limit", obs_of(1), {24'h999999, 3'b110});
    chk("down_wrap_hms", obs_of(2), {24'h235959, 3'b110});
    run(3, 1'b0);

    // Invalid loads and prescaler restart on valid load.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 24'h0000A5);
    chk("bad_digit_err", {26'h0, lerr_o[0]}, 27'h1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 24'h240000);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 24'h123456);
    chk("load_ok", {3'b0, dout[0]}, {3'b0, 24'h123456});
    run(6, 1'b1);

    // Priority: clear > load > step; en=0 freezes.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 24'h123456);
    chk("clear_wins", obs_of(1), 27'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 24'h000777);
    chk("load_beats_step", obs_of(1), {24'h000777, 3'b000});
    run(2, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    run(5, 1'b1);

    // Asynchronous reset mid-prescale.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 24'h000457);
    run(2, 1'b1);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_rst_dut%0d", k), obs_of(k), 27'h0);
      m[k] = '{0, 0, 0, 0, 0};
    end
    #1;
    rst = 1'b0;
    run(3, 1'b1);
    chk("post_rst_no_tick", {26'h0, tick_o[0]}, 27'h0);
    run(1, 1'b1);
    chk("post_rst_tick", obs_of(0), {24'h000001, 3'b100});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
